mips_multicycle_core: RTL and testbench

//  Parametrised multi-cycle MIPS integer core: next generation of the single-cycle CPU.
//  - Takes one instruction at a time over a valid/ready handshake.
//  - Sequences FETCH/EXEC/WB through an explicit FSM; owns the PC and the register file.
//  - Adds taken branches, JR redirect, ADDI writeback to rt, illegal-op flag, debug read port.

---
 rtl/mips_multicycle_core.sv | 105 ++++++++++
 tb/tb_mips_multicycle_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS integer core with IDLE/EXEC/WB sequencing, PC and register file.
// Define MIPS_SHIFT_EN to add R-type SLL/SRL; otherwise those functs retire as illegal.
module mips_multicycle_core #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t            st_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] alu_q, alu_d, result_q;
  logic [PC_W-1:0]   pc_q, npc_q, npc_d;
  logic [4:0]        wa_q, wa_d;
  logic              wen_q, wen_d, ill_q, ill_d, rv_q, il_q;
  logic [DATA_W-1:0] a, b, simm, sub;
  logic [PC_W-1:0]   pc4, tgt;
  assign a           = regs_q[ir_q[25:21]];
  assign b           = regs_q[ir_q[20:16]];
  assign simm        = DATA_W'($signed(ir_q[15:0]));
  assign sub         = a - b;
  assign pc4         = pc_q + PC_W'(4);
  assign tgt         = pc4 + PC_W'($signed({ir_q[15:0], 2'b00}));
  assign instr_ready = st_q == IDLE;
  assign pc          = pc_q;
  assign result      = result_q;
  assign result_valid = rv_q;
  assign illegal     = il_q;
  assign dbg_data    = dbg_addr == 5'd0 ? '0 : regs_q[dbg_addr];
  always_comb begin
    alu_d = '0;
    wen_d = 1'b0;
    wa_d  = ir_q[15:11];
    npc_d = pc4;
    ill_d = 1'b0;
    case (ir_q[31:26])
      6'h00: case (ir_q[5:0])
        6'h20: begin alu_d = a + b; wen_d = 1'b1; end
        6'h22: begin alu_d = sub; wen_d = 1'b1; end
        6'h24: begin alu_d = a & b; wen_d = 1'b1; end
        6'h2a: begin alu_d = DATA_W'($signed(a) < $signed(b)); wen_d = 1'b1; end
        6'h08: begin alu_d = a; npc_d = PC_W'(a); end
`ifdef MIPS_SHIFT_EN
        6'h00: begin alu_d = b << ir_q[10:6]; wen_d = 1'b1; end
        6'h02: begin alu_d = b >> ir_q[10:6]; wen_d = 1'b1; end
`endif
        default: ill_d = 1'b1;
      endcase
      6'h08: begin alu_d = a + simm; wen_d = 1'b1; wa_d = ir_q[20:16]; end
      6'h04: begin alu_d = sub; npc_d = sub == '0 ? tgt : pc4; end
      6'h05: begin alu_d = sub; npc_d = sub != '0 ? tgt : pc4; end
      6'h0a: begin alu_d = DATA_W'($signed(a) < $signed(b)); npc_d = $signed(a) < $signed(b) ? tgt : pc4; end
      6'h0b: begin alu_d = DATA_W'($signed(b) < $signed(a)); npc_d = $signed(b) < $signed(a) ? tgt : pc4; end
      default: ill_d = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q     <= IDLE;
      pc_q     <= PC_RESET;
      result_q <= '0;
      rv_q     <= 1'b0;
      il_q     <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      rv_q <= 1'b0;
      il_q <= 1'b0;
      case (st_q)
        IDLE: if (instr_valid) begin
          ir_q <= instr;
          st_q <= EXEC;
        end
        EXEC: begin
          alu_q <= alu_d;
          wen_q <= wen_d;
          wa_q  <= wa_d;
          npc_q <= npc_d;
          ill_q <= ill_d;
          st_q  <= WB;
        end
        WB: begin
          if (wen_q && wa_q != 5'd0) regs_q[wa_q] <= alu_q;
          pc_q     <= npc_q;
          result_q <= alu_q;
          rv_q     <= 1'b1;
          il_q     <= ill_q;
          st_q     <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboard bench for mips_multicycle_core (32-bit, PC_RESET=0).
module tb_mips_multicycle_core;
  logic        clk = 0, reset_n = 0, instr_valid = 0;
  logic [31:0] instr = '0;
  logic [4:0]  dbg_addr = '0;
  logic        instr_ready, result_valid, illegal;
  logic [31:0] pc, result, dbg_data;
  typedef struct packed {logic [31:0] res; logic ill; logic [31:0] pc;} exp_t;
  exp_t sb[$];
  int   rv_cyc[$];
  int   cyc = 0, n_tests = 0, n_fail = 0;
  mips_multicycle_core #(.DATA_W(32), .PC_W(32), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .result(result), .result_valid(result_valid), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (result_valid) begin
    exp_t e;
    rv_cyc.push_back(cyc);
    check("rv_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result", result, e.res);
      check("illegal", 32'(illegal), 32'(e.ill));
      check("pc", pc, e.pc);
    end
  end
  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rtt, input logic [4:0] sh);
    return {6'd0, rs, rtt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rtt,
                                     input logic [15:0] imm);
    return {op, rs, rtt, imm};
  endfunction
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(instr_ready), 32'd1);
  endtask
  task automatic issue(input logic [31:0] w, input logic [31:0] res, input logic ill, input logic [31:0] epc);
    wait_ready();
    instr_valid = 1'b1;
    instr = w;
    sb.push_back('{res, ill, epc});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = $urandom;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask
  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] e);
    dbg_addr = a;
    #1 check(tag, dbg_data, e);
  endtask
  task automatic reset_in(input int stage);
    int nrv;
    wait_ready();
    instr_valid = 1'b1;
    instr = it(6'h08, 5'd0, 5'd6, 16'd9);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    if (stage == 1) begin
      @(posedge clk);
      #1;
    end
    nrv = rv_cyc.size();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_rv", rv_cyc.size(), nrv);
    check("rst_pc", pc, 32'h0);
    dbg("rst_r6", 5'd6, 32'h0);
  endtask
  initial begin
    logic [31:0] p, r;
    int g;
    repeat (2) @(posedge clk);
    #1;
    check("t1_pc", pc, 32'h0);
    check("t1_result", result, 32'h0);
    check("t1_rv", 32'(result_valid), 32'd0);
    check("t1_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 32; i++) dbg("t1_dbg", 5'(i), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    // T2: ADDI/ADD, back-to-back to measure retirement spacing
    g = rv_cyc.size();
    issue(it(6'h08, 5'd0, 5'd1, 16'd5), 32'd5, 1'b0, 32'd4);
    issue(it(6'h08, 5'd0, 5'd2, 16'hFFFD), 32'hFFFFFFFD, 1'b0, 32'd8);
    issue(rt(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), 32'd2, 1'b0, 32'd12);
    drain();
    check("t2_gap1", rv_cyc[g+1] - rv_cyc[g], 32'd3);
    check("t2_gap2", rv_cyc[g+2] - rv_cyc[g+1], 32'd3);
    dbg("t2_r3", 5'd3, 32'd2);
    // T3: branches and signed compares
    issue(it(6'h08, 5'd0, 5'd1, 16'd4), 32'd4, 1'b0, 32'd16);
    issue(it(6'h08, 5'd0, 5'd2, 16'd4), 32'd4, 1'b0, 32'd20);
    issue(it(6'h04, 5'd1, 5'd2, 16'd2), 32'd0, 1'b0, 32'd32);
    issue(it(6'h05, 5'd1, 5'd2, 16'd2), 32'd0, 1'b0, 32'd36);
    issue(it(6'h0a, 5'd0, 5'd1, 16'hFFFF), 32'd1, 1'b0, 32'd36);
    issue(it(6'h0b, 5'd0, 5'd1, 16'd5), 32'd0, 1'b0, 32'd40);
    issue(it(6'h05, 5'd1, 5'd3, 16'hFFFE), 32'd2, 1'b0, 32'd36);
    issue(it(6'h08, 5'd0, 5'd8, 16'hFFFD), 32'hFFFFFFFD, 1'b0, 32'd40);
    issue(rt(6'h2a, 5'd9, 5'd8, 5'd1, 5'd0), 32'd1, 1'b0, 32'd44);
    issue(rt(6'h22, 5'd10, 5'd8, 5'd1, 5'd0), 32'hFFFFFFF9, 1'b0, 32'd48);
    issue(rt(6'h24, 5'd11, 5'd8, 5'd1, 5'd0), 32'd4, 1'b0, 32'd52);
    issue(rt(6'h2a, 5'd14, 5'd1, 5'd8, 5'd0), 32'd0, 1'b0, 32'd56);
    drain();
    dbg("t3_r9", 5'd9, 32'd1);
    dbg("t3_r10", 5'd10, 32'hFFFFFFF9);
    // T4: r0 stays zero, JR redirect
    issue(it(6'h08, 5'd0, 5'd0, 16'd7), 32'd7, 1'b0, 32'd60);
    drain();
    dbg("t4_r0", 5'd0, 32'h0);
    issue(rt(6'h20, 5'd12, 5'd0, 5'd0, 5'd0), 32'd0, 1'b0, 32'd64);
    issue(it(6'h08, 5'd0, 5'd5, 16'h0100), 32'h100, 1'b0, 32'd68);
    issue(rt(6'h08, 5'd0, 5'd5, 5'd0, 5'd0), 32'h100, 1'b0, 32'h100);
    // T5: illegal opcodes and shifts
    issue(32'hFC000000, 32'd0, 1'b1, 32'h104);
    drain();
    dbg("t5_r1", 5'd1, 32'd4);
`ifdef MIPS_SHIFT_EN
    issue(rt(6'h00, 5'd4, 5'd0, 5'd1, 5'd3), 32'd32, 1'b0, 32'h108);
    issue(32'h0, 32'd0, 1'b0, 32'h10C);
    issue(rt(6'h3f, 5'd4, 5'd1, 5'd1, 5'd0), 32'd0, 1'b1, 32'h110);
    issue(rt(6'h02, 5'd15, 5'd0, 5'd8, 5'd28), 32'hF, 1'b0, 32'h114);
    drain();
    dbg("t5_r4", 5'd4, 32'd32);
`else
    issue(rt(6'h00, 5'd4, 5'd0, 5'd1, 5'd3), 32'd0, 1'b1, 32'h108);
    issue(32'h0, 32'd0, 1'b1, 32'h10C);
    issue(rt(6'h3f, 5'd4, 5'd1, 5'd1, 5'd0), 32'd0, 1'b1, 32'h110);
    issue(rt(6'h02, 5'd15, 5'd0, 5'd8, 5'd28), 32'd0, 1'b1, 32'h114);
    drain();
    dbg("t5_r4", 5'd4, 32'd0);
`endif
    // PC wrap from the top of the address space
    issue(it(6'h08, 5'd0, 5'd13, 16'hFFFC), 32'hFFFFFFFC, 1'b0, 32'h118);
    issue(rt(6'h08, 5'd0, 5'd13, 5'd0, 5'd0), 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC);
    issue(it(6'h08, 5'd0, 5'd0, 16'd1), 32'd1, 1'b0, 32'h0);
    drain();
    p = pc;
    r = result;
    repeat (5) @(negedge clk);
    check("idle_pc", pc, p);
    check("idle_result", result, r);
    check("idle_ready", 32'(instr_ready), 32'd1);
    // T6: reset during EXEC, then during WB
    issue(it(6'h08, 5'd0, 5'd6, 16'd9), 32'd9, 1'b0, 32'd4);
    drain();
    reset_in(0);
    issue(it(6'h08, 5'd0, 5'd6, 16'd9), 32'd9, 1'b0, 32'd4);
    drain();
    reset_in(1);
    issue(it(6'h08, 5'd0, 5'd6, 16'd9), 32'd9, 1'b0, 32'd4);
    drain();
    dbg("t6_r6", 5'd6, 32'd9);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
